// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// with the trial subtract built from 4-bit carry-lookahead groups.
module restoring_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int GROUPS = WIDTH / 4;
  localparam int CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Partial remainder stays below M after every restore, so WIDTH bits hold it;
  // only the shifted value S needs the extra top bit.
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] a;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] bit_p;
  logic [WIDTH-1:0] bit_g;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             last_iter;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  assign s     = {a, q[WIDTH-1]};
  assign op_a  = s[WIDTH-1:0];
  assign op_b  = ~m;
  assign bit_p = op_a ^ op_b;
  assign bit_g = op_a & op_b;

  // Subtraction as A + ~M + 1: the +1 enters as the carry into group 0.
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_cla
    localparam int B = 4 * gi;
    logic p0, p1, p2, p3;
    logic g0, g1, g2, g3;
    logic cin;
    logic grp_p;
    logic grp_g;

    assign p0  = bit_p[B];
    assign p1  = bit_p[B+1];
    assign p2  = bit_p[B+2];
    assign p3  = bit_p[B+3];
    assign g0  = bit_g[B];
    assign g1  = bit_g[B+1];
    assign g2  = bit_g[B+2];
    assign g3  = bit_g[B+3];
    assign cin = carry[B];

    assign carry[B+1] = g0 | (p0 & cin);
    assign carry[B+2] = g1 | (p1 & g0) | (p1 & p0 & cin);
    assign carry[B+3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & cin);

    assign grp_p = p3 & p2 & p1 & p0;
    assign grp_g = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);

    // Group carries ripple from one 4-bit block to the next.
    assign carry[B+4] = grp_g | (grp_p & cin);
  end

  assign diff = bit_p ^ carry[WIDTH-1:0];

  // Top bit of S against a zero top bit of M (inverted to 1): carry-out is S[W] | c.
  assign no_borrow = s[WIDTH] | carry[WIDTH];
  assign a_next    = no_borrow ? diff : s[WIDTH-1:0];
  assign q_next    = {q[WIDTH-2:0], no_borrow};
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (Run) begin
          state_next = (Divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    unique case (state)
      CALC:    Busy = 1'b1;
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: reset clears every datapath register too, so a discarded operation
  // leaves nothing behind and the outputs read zero right after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m         <= '0;
      q         <= '0;
      a         <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Run) begin
            m     <= Divisor;
            q     <= Dividend;
            a     <= '0;
            count <= '0;
            if (Divisor == '0) begin
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end
          end
        end
        CALC: begin
          a     <= a_next;
          q     <= q_next;
          count <= count + CNT_W'(1);
          if (last_iter) begin
            Quotient  <= q_next;
            Remainder <= a_next;
            DivByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed checks of restoring_divider_8bit: latency, edge cases, ignored Run,
// mid-operation reset, back-to-back throughput and a sampled sweep against a / and % model.
module tb_restoring_divider_8bit;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_compared   = 0;
  int n_mismatched = 0;

  restoring_divider_8bit #(.WIDTH(8)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Run       (run),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Starts an op at the next edge, optionally pokes Run with 50/5 at edge E_poke,
  // then waits (bounded) for Done and checks latency, Busy length and results.
  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_q, input logic [7:0] exp_r, input logic exp_dbz,
                        input int exp_lat, input int poke);
    int         lat;
    int         busy_cycles;
    logic       held;
    logic [7:0] q_before;
    q_before = quotient;
    held     = 1'b1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    @(negedge clk);
    run         = 1'b0;
    dividend    = 8'($urandom);
    divisor     = 8'($urandom);
    lat         = 1;
    busy_cycles = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cycles++;
      if (busy && quotient !== q_before) held = 1'b0;
      @(negedge clk);
      lat++;
      if (poke > 0 && lat == poke) begin
        run      = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end else begin
        run = 1'b0;
      end
    end
    run = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    check({tag, " held_during_calc"}, 32'(held), 32'd1);
  endtask

  initial begin
    int         lat;
    int         gap;
    logic       saw_done;
    logic [7:0] ra;
    logic [7:0] rb;

    reset    = 1'b1;
    run      = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    do_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 0);
    do_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 0);
    do_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 0);
    do_div("0/3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9, 0);
    do_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, 0);
    do_div("254/255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9, 0);
    do_div("200/0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1, 0);
    do_div("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 0);

    // Run pulsed with 50/5 so that it is sampled at E3: must be ignored.
    do_div("100/7 poke", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 3);
    @(negedge clk);
    check("after poke idle busy", 32'(busy), 32'd0);
    check("after poke idle done", 32'(done), 32'd0);

    // Reset sampled at E4 of a 100/7 operation.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    run      = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset quotient", 32'(quotient), 32'd0);
    check("midreset remainder", 32'(remainder), 32'd0);
    check("midreset div_by_zero", 32'(div_by_zero), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check("midreset no activity", 32'(saw_done), 32'd0);
    do_div("81/9", 8'd81, 8'd9, 8'd9, 8'd0, 1'b0, 9, 0);

    // Run held high: one result every WIDTH+2 cycles.
    @(negedge clk);
    dividend = 8'd17;
    divisor  = 8'd5;
    run      = 1'b1;
    lat      = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("held first done", 32'(done), 32'd1);
    check("held first latency", 32'(lat), 32'd9);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      @(negedge clk);
      gap++;
      while (!done && gap < 30) begin
        @(negedge clk);
        gap++;
      end
      check($sformatf("held gap %0d", k), 32'(gap), 32'd10);
      check($sformatf("held quotient %0d", k), 32'(quotient), 32'd3);
      check($sformatf("held remainder %0d", k), 32'(remainder), 32'd2);
    end
    run = 1'b0;
    @(negedge clk);

    // Sampled sweep against the language's / and % operators.
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 25 == 0) rb = 8'd0;
      if (rb == 8'd0) begin
        do_div($sformatf("rand %0d/%0d", ra, rb), ra, rb, 8'd255, ra, 1'b1, 1, 0);
      end else begin
        do_div($sformatf("rand %0d/%0d", ra, rb), ra, rb, ra / rb, ra % rb, 1'b0, 9, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
